photon_gate_counter: RTL and testbench

Upstream feeder for the histogram shift-and-draw stage. It samples the asynchronous photon-detector pulse line, deglitches it, and counts rising edges over a fixed gate window. At each window end it scales and clamps the count to the drawable histogram height. It then presents the result on oPulseCounter with a one-cycle oDataUpdate strobe, which the draw stage latches.

---
 rtl/photon_pkg.sv | 27 ++
 rtl/pulse_edge_sync.sv | 54 +++++
 rtl/photon_gate_counter.sv | 154 +++++++++++++++
 tb/tb_photon_gate_counter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/photon_pkg.sv
// Shared constants, FSM encoding and helpers for the photon gate counter.
package photon_pkg;

    localparam int PULSE_W   = 16;
    localparam int RAW_W     = 32;

    // Drawable histogram span in pixels; the count is clamped to this height.
    localparam int HIST_X0   = 12;
    localparam int HIST_X1   = 228;
    localparam int CLAMP_MAX = HIST_X1 - HIST_X0;

    // One second at 50 MHz.
    localparam int unsigned GATE_CYCLES_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_LATCH = 2'd3
    } gate_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RAW_W-1:0] sat_inc(input logic [RAW_W-1:0] v);
        return (v == {RAW_W{1'b1}}) ? v : v + RAW_W'(1);
    endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Synchronizes the asynchronous detector line, rejects short glitches and
// emits a single-cycle edge per accepted high period.
module pulse_edge_sync #(
    parameter int unsigned DEGLITCH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    output logic edge_o
);

    // The edge fires on the DEGLITCH-th consecutive high sample; the run
    // counter then parks one above that so the same high period cannot fire again.
    localparam logic [3:0] HIT_CNT = 4'(DEGLITCH - 1);
    localparam logic [3:0] SAT_CNT = 4'(DEGLITCH);

    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] run_q;
    logic [3:0] run_d;

    // Two-flop synchronizer on the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive synced-high samples; any low sample restarts the run.
    always_comb begin
        run_d = run_q;
        if (!sync2_q) begin
            run_d = '0;
        end else if (run_q != SAT_CNT) begin
            run_d = run_q + 4'd1;
        end
    end

    // Run-length register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign edge_o = sync2_q && (run_q == HIT_CNT);

endmodule

// File: rtl/photon_gate_counter.sv
// Counts deglitched detector pulses over back-to-back gate windows and
// publishes a scaled, clamped count with a one-cycle update strobe.
module photon_gate_counter #(
    parameter int unsigned GATE_CYCLES = photon_pkg::GATE_CYCLES_DEFAULT,
    parameter int unsigned DEGLITCH    = 1,
    parameter int unsigned CLAMP_MAX   = photon_pkg::CLAMP_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        iPulse,
    input  logic [3:0]  iScaleShift,
    output logic [15:0] oPulseCounter,
    output logic        oDataUpdate,
    output logic [31:0] oRawCount,
    output logic        oClamped,
    output logic        oOverflow
);
    import photon_pkg::*;

    localparam logic [RAW_W-1:0]   TIMER_LOAD = RAW_W'(GATE_CYCLES - 1);
    localparam logic [RAW_W-1:0]   CLAMP_RAW  = RAW_W'(CLAMP_MAX);
    localparam logic [PULSE_W-1:0] CLAMP_PC   = PULSE_W'(CLAMP_MAX);

    gate_state_e        state_q, state_d;
    logic [RAW_W-1:0]   timer_q, timer_d;
    logic [RAW_W-1:0]   raw_q, raw_d;
    logic               ovf_q, ovf_d;

    logic [PULSE_W-1:0] pc_q;
    logic [RAW_W-1:0]   rawout_q;
    logic               clamped_q;
    logic               ovfout_q;

    logic               edge_w;
    logic               latch_w;
    logic [RAW_W-1:0]   scaled_w;
    logic               clamp_hit_w;
    logic [PULSE_W-1:0] pc_res_w;

    pulse_edge_sync #(
        .DEGLITCH (DEGLITCH)
    ) u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_i (iPulse),
        .edge_o  (edge_w)
    );

    assign latch_w = (state_q == ST_LATCH);

    // Gate window sequencing: timer, raw pulse count and overflow flag.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        raw_d   = raw_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                raw_d   = '0;
                ovf_d   = 1'b0;
                if (en) state_d = ST_ARM;
            end
            ST_ARM: begin
                timer_d = TIMER_LOAD;
                raw_d   = '0;
                ovf_d   = 1'b0;
                state_d = ST_COUNT;
                if (!en) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            ST_COUNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    raw_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    // An edge in the timer==0 cycle still belongs to this window.
                    if (edge_w) begin
                        raw_d = sat_inc(raw_q);
                        if (raw_q == {RAW_W{1'b1}}) ovf_d = 1'b1;
                    end
                    if (timer_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        timer_d = timer_q - RAW_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                // Next window starts here, so an edge this cycle is its first count.
                timer_d = TIMER_LOAD;
                raw_d   = edge_w ? RAW_W'(1) : '0;
                ovf_d   = 1'b0;
                state_d = ST_COUNT;
                if (!en) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    raw_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and counting registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            raw_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            raw_q   <= raw_d;
            ovf_q   <= ovf_d;
        end
    end

    // Window result: shift first, then clamp the full 32-bit value.
    always_comb begin
        scaled_w    = raw_q >> iScaleShift;
        clamp_hit_w = (scaled_w > CLAMP_RAW);
        pc_res_w    = clamp_hit_w ? CLAMP_PC : scaled_w[PULSE_W-1:0];
    end

    // Hold the published result from the LATCH cycle until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            rawout_q  <= '0;
            clamped_q <= 1'b0;
            ovfout_q  <= 1'b0;
        end else if (latch_w) begin
            pc_q      <= pc_res_w;
            rawout_q  <= raw_q;
            clamped_q <= clamp_hit_w;
            ovfout_q  <= ovf_q;
        end
    end

    // The new result is visible in the strobe cycle itself.
    assign oDataUpdate   = latch_w;
    assign oPulseCounter = latch_w ? pc_res_w    : pc_q;
    assign oRawCount     = latch_w ? raw_q       : rawout_q;
    assign oClamped      = latch_w ? clamp_hit_w : clamped_q;
    assign oOverflow     = latch_w ? ovf_q       : ovfout_q;

endmodule

// File: tb/tb_photon_gate_counter.sv
// Scoreboard bench for photon_gate_counter: three configurations driven with
// pulse trains whose window totals are derived from pulse timing arithmetic.
`timescale 1ns/1ps
module tb_photon_gate_counter;

    localparam int NDUT  = 3;
    localparam int GC [NDUT] = '{100, 1000, 100};
    localparam int DG [NDUT] = '{1, 1, 3};
    localparam int CLAMP = 216;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] pc;
        logic [31:0] raw;
        logic        clamp;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [NDUT];
    logic        en    [NDUT];
    logic        pulse [NDUT];
    logic [3:0]  shift [NDUT];
    logic [15:0] pc    [NDUT];
    logic        upd   [NDUT];
    logic [31:0] rawc  [NDUT];
    logic        clmp  [NDUT];
    logic        ovf   [NDUT];

    exp_t exp_q [NDUT][$];
    exp_t last_exp [NDUT];
    int   sched_r[$];
    int   sched_w[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    photon_gate_counter #(.GATE_CYCLES(100), .DEGLITCH(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .iPulse(pulse[0]), .iScaleShift(shift[0]),
        .oPulseCounter(pc[0]), .oDataUpdate(upd[0]), .oRawCount(rawc[0]),
        .oClamped(clmp[0]), .oOverflow(ovf[0]));

    photon_gate_counter #(.GATE_CYCLES(1000), .DEGLITCH(1)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .iPulse(pulse[1]), .iScaleShift(shift[1]),
        .oPulseCounter(pc[1]), .oDataUpdate(upd[1]), .oRawCount(rawc[1]),
        .oClamped(clmp[1]), .oOverflow(ovf[1]));

    photon_gate_counter #(.GATE_CYCLES(100), .DEGLITCH(3)) dut2 (
        .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .iPulse(pulse[2]), .iScaleShift(shift[2]),
        .oPulseCounter(pc[2]), .oDataUpdate(upd[2]), .oRawCount(rawc[2]),
        .oClamped(clmp[2]), .oOverflow(ovf[2]));

    task automatic chk(input string name, input int dut, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d @cycle %0d: got %0d, expected %0d", name, dut, cyc, got, want);
        end
    endtask

    // Monitor: pops an expectation on every strobe, otherwise outputs must hold.
    logic [15:0] prev_pc   [NDUT];
    logic [31:0] prev_raw  [NDUT];
    logic        prev_clmp [NDUT];
    logic        prev_ovf  [NDUT];
    logic        prev_upd  [NDUT];
    exp_t        mon_e;

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst_n[i] && upd[i]) begin
                chk("strobe_single_cycle", i, prev_upd[i], 0);
                if (exp_q[i].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe dut%0d @cycle %0d: got strobe, expected none", i, cyc);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    chk("strobe_cycle", i, cyc, mon_e.cyc);
                    chk("pulse_counter", i, pc[i], mon_e.pc);
                    chk("raw_count", i, rawc[i], mon_e.raw);
                    chk("clamped", i, clmp[i], mon_e.clamp);
                    chk("overflow", i, ovf[i], mon_e.ovf);
                end
            end else if (rst_n[i]) begin
                chk("hold_pulse_counter", i, pc[i], prev_pc[i]);
                chk("hold_raw_count", i, rawc[i], prev_raw[i]);
                chk("hold_clamped", i, clmp[i], prev_clmp[i]);
                chk("hold_overflow", i, ovf[i], prev_ovf[i]);
            end
            prev_pc[i]   <= pc[i];
            prev_raw[i]  <= rawc[i];
            prev_clmp[i] <= clmp[i];
            prev_ovf[i]  <= ovf[i];
            prev_upd[i]  <= rst_n[i] ? upd[i] : 1'b0;
        end
    end

    // Append n pulses starting at offset 'start' (relative to the ARM cycle).
    task automatic add_train(input int start, input int n, input int wmin, input int wmax,
                             input int gmin, input int gmax);
        int t;
        int w;
        t = start;
        for (int i = 0; i < n; i++) begin
            w = int'($urandom_range(wmax, wmin));
            sched_r.push_back(t);
            sched_w.push_back(w);
            t = t + w + int'($urandom_range(gmax, gmin));
        end
    endtask

    task automatic clear_sched();
        sched_r = {};
        sched_w = {};
    endtask

    // Raise en, play the schedule, expect nwin strobes, drop en 'extra' cycles
    // after the last expected strobe. Pin high at offset r becomes an accepted
    // edge at offset r+1+D; window k owns offsets [k(G+1), k(G+1)+G] (offset 0 = ARM).
    task automatic run_scn(input int id, input int nwin, input int extra, input int sh,
                           input bit rel_rst);
        int g, d, a, len, e, kw;
        int cnt [];
        bit lvl [];
        logic [31:0] scaled;
        exp_t x;
        g   = GC[id];
        d   = DG[id];
        len = nwin * (g + 1) + extra;
        lvl = new[len + 1];
        cnt = new[nwin];
        for (int t = 0; t <= len; t++) lvl[t] = 1'b0;
        for (int k = 0; k < nwin; k++) cnt[k] = 0;
        for (int j = 0; j < sched_r.size(); j++) begin
            for (int t = sched_r[j]; t < sched_r[j] + sched_w[j] && t <= len; t++) lvl[t] = 1'b1;
            if (sched_w[j] >= d) begin
                e  = sched_r[j] + 1 + d;
                kw = e / (g + 1);
                if (kw < nwin) cnt[kw]++;
            end
        end
        @(posedge clk); #1;
        shift[id] = 4'(sh);
        pulse[id] = 1'b0;
        en[id]    = 1'b1;
        if (rel_rst) rst_n[id] = 1'b1;
        a = cyc + 1;
        for (int k = 0; k < nwin; k++) begin
            scaled  = 32'(cnt[k]) >> sh;
            x.cyc   = 32'(a + (k + 1) * (g + 1));
            x.raw   = 32'(cnt[k]);
            x.clamp = (scaled > 32'(CLAMP));
            x.pc    = x.clamp ? 16'(CLAMP) : scaled[15:0];
            x.ovf   = 1'b0;
            exp_q[id].push_back(x);
            last_exp[id] = x;
        end
        for (int t = 0; t <= len; t++) begin
            @(posedge clk); #1;
            pulse[id] = lvl[t];
            if (t == len) en[id] = 1'b0;
        end
        @(posedge clk); #1;
        pulse[id] = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic chk_outputs(input string tag, input int id, input logic [15:0] wpc,
                               input logic [31:0] wraw, input logic wclamp, input logic wovf,
                               input logic wupd);
        chk({tag, "_pulse_counter"}, id, pc[id], wpc);
        chk({tag, "_raw_count"}, id, rawc[id], wraw);
        chk({tag, "_clamped"}, id, clmp[id], wclamp);
        chk({tag, "_overflow"}, id, ovf[id], wovf);
        chk({tag, "_update"}, id, upd[id], wupd);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst_n[i] = 1'b0;
            en[i]    = 1'b0;
            pulse[i] = 1'b0;
            shift[i] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) chk_outputs("reset", i, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NDUT; i++) rst_n[i] = 1'b1;
        repeat (5) @(posedge clk);

        // Ten 2-high/2-low pulses, no scaling.
        clear_sched();
        add_train(5, 10, 2, 2, 2, 2);
        run_scn(0, 1, 0, 0, 1'b0);

        // 37 pulses divided by 4.
        clear_sched();
        add_train(3, 37, 1, 1, 1, 1);
        run_scn(0, 1, 0, 2, 1'b0);

        // 400 pulses in a 1000-cycle window clamp to the histogram height.
        clear_sched();
        add_train(10, 400, 1, 1, 1, 1);
        run_scn(1, 1, 0, 0, 1'b0);

        // Edges in the timer==0 cycle and in the LATCH cycle.
        clear_sched();
        sched_r = '{10, 98, 150, 200, 250};
        sched_w = '{1, 1, 1, 1, 1};
        run_scn(0, 3, 0, 0, 1'b0);

        // Abort 50 cycles into window 2, then a fresh window.
        clear_sched();
        add_train(0, 20, 1, 2, 1, 3);
        add_train(110, 10, 1, 2, 1, 3);
        run_scn(0, 1, 50, 1, 1'b0);
        chk("abort_hold_raw", 0, rawc[0], last_exp[0].raw);
        chk("abort_hold_pc", 0, pc[0], last_exp[0].pc);
        clear_sched();
        add_train(4, 15, 1, 3, 1, 3);
        run_scn(0, 1, 0, 0, 1'b0);

        // Randomized multi-window runs.
        for (int r = 0; r < 4; r++) begin
            clear_sched();
            add_train(int'($urandom_range(5, 0)), int'($urandom_range(70, 20)), 1, 3, 1, 3);
            run_scn(0, 3, 0, int'($urandom_range(3, 0)), 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            clear_sched();
            add_train(int'($urandom_range(5, 0)), int'($urandom_range(320, 150)), 1, 2, 1, 2);
            run_scn(1, 1, 0, int'($urandom_range(1, 0)), 1'b0);
        end

        // Deglitch of 3: short pulses rejected, 3-wide pulses counted.
        clear_sched();
        add_train(2, 10, 2, 2, 2, 3);
        run_scn(2, 1, 0, 0, 1'b0);
        clear_sched();
        add_train(2, 6, 2, 2, 2, 2);
        add_train(30, 5, 3, 3, 2, 2);
        run_scn(2, 1, 0, 0, 1'b0);
        clear_sched();
        add_train(0, 40, 1, 5, 1, 3);
        run_scn(2, 2, 0, 0, 1'b0);

        // Reset asserted mid-window, then a full window after release.
        clear_sched();
        add_train(2, 6, 3, 3, 2, 2);
        run_scn(2, 1, 0, 0, 1'b0);
        @(posedge clk); #1;
        en[2] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            pulse[2] = (t % 8) < 4;
        end
        rst_n[2] = 1'b0;
        pulse[2] = 1'b0;
        #1;
        chk_outputs("midwin_reset", 2, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        clear_sched();
        add_train(6, 8, 3, 4, 1, 3);
        run_scn(2, 1, 0, 0, 1'b1);

        repeat (20) @(posedge clk);
        for (int i = 0; i < NDUT; i++) chk("pending_strobes", i, exp_q[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
